// File: rtl/invaders_pkg.sv
// Shared types and screen constants for the invaders blocks (player, bullet, renderer).
package invaders_pkg;

  typedef enum logic [1:0] {ALIVE, DYING, INVULN, GAME_OVER} life_state_t;
  typedef enum logic [1:0] {READY, REQ, COOL} fire_state_t;

  localparam int JOY_LEFT_THRESH  = 4;
  localparam int JOY_RIGHT_THRESH = 6;

  localparam int SCREEN_MIN_COL   = 5;
  localparam int SCREEN_MAX_COL   = 600;
  localparam int PLAYER_ROW       = 420;
  localparam int PLAYER_START_COL = 310;

  // Counter width able to hold 0..n.
  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/player_fire_ctrl.sv
// Fire FSM: holds the bullet request until acked, then a frame-tick cooldown.
module player_fire_ctrl
  import invaders_pkg::*;
#(
  parameter int COL_W     = 10,
  parameter int COOLDOWN  = 15,
  parameter int START_COL = 310
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             frame_tick,
  input  logic             fire_btn,
  input  logic             fire_enable,
  input  logic             bullet_ack,
  input  logic [COL_W-1:0] player_col,
  output logic             bullet_req,
  output logic [COL_W-1:0] bullet_col
);

  localparam int CW = cnt_w(COOLDOWN);

  fire_state_t     state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [COL_W-1:0] bcol_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= READY;
      cnt        <= '0;
      bullet_col <= COL_W'(START_COL);
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      bullet_col <= bcol_nxt;
    end
  end

  // Once in REQ nothing but the ack moves us on, so a hit cannot cancel a request.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    bcol_nxt  = bullet_col;
    case (state)
      READY: if (fire_btn && fire_enable) begin
        state_nxt = REQ;
        bcol_nxt  = player_col;
      end
      REQ: if (bullet_ack) begin
        state_nxt = COOL;
        cnt_nxt   = CW'(COOLDOWN);
      end
      COOL: begin
        if (cnt == '0)      state_nxt = READY;
        else if (frame_tick) cnt_nxt  = cnt - CW'(1);
      end
      default: state_nxt = READY;
    endcase
  end

  assign bullet_req = (state == REQ);

endmodule

// File: rtl/player_ctrl.sv
// Player ship: clamped joystick movement, lives/respawn FSM, fire via player_fire_ctrl.
// Define PLAYER_INVULN_EN to add a blinking invulnerable phase after each respawn.
module player_ctrl
  import invaders_pkg::*;
#(
  parameter int ROW_W          = 9,
  parameter int COL_W          = 10,
  parameter int START_ROW      = PLAYER_ROW,
  parameter int START_COL      = PLAYER_START_COL,
  parameter int MIN_COL        = SCREEN_MIN_COL,
  parameter int MAX_COL        = SCREEN_MAX_COL,
  parameter int STEP           = 5,
  parameter int JOY_LEFT_TH    = JOY_LEFT_THRESH,
  parameter int JOY_RIGHT_TH   = JOY_RIGHT_THRESH,
  parameter int COOLDOWN       = 15,
  parameter int LIVES          = 3,
  parameter int RESPAWN_FRAMES = 60
`ifdef PLAYER_INVULN_EN
  , parameter int INVULN_FRAMES = 90
`endif
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Frame_tick,
  input  logic [3:0]       Joystick_data,
  input  logic             Fire_btn,
  input  logic             Hit,
  input  logic             Bullet_ack,
  output logic [ROW_W-1:0] Player_Row,
  output logic [COL_W-1:0] Player_Col,
  output logic             Bullet_req,
  output logic [COL_W-1:0] Bullet_col,
  output logic             Visible,
  output logic [2:0]       Lives,
  output logic             Game_over
);

`ifdef PLAYER_INVULN_EN
  localparam int FRAMES_MAX = (RESPAWN_FRAMES > INVULN_FRAMES) ? RESPAWN_FRAMES : INVULN_FRAMES;
`else
  localparam int FRAMES_MAX = RESPAWN_FRAMES;
`endif
  localparam int TW = cnt_w(FRAMES_MAX);

  // One extra bit so col+STEP and the left-bound test cannot wrap.
  localparam logic [COL_W:0] STEP_X  = (COL_W+1)'(STEP);
  localparam logic [COL_W:0] MIN_X   = (COL_W+1)'(MIN_COL);
  localparam logic [COL_W:0] MAX_X   = (COL_W+1)'(MAX_COL);
  localparam logic [3:0]     JOY_L   = 4'(JOY_LEFT_TH);
  localparam logic [3:0]     JOY_R   = 4'(JOY_RIGHT_TH);

  life_state_t      life, life_nxt;
  logic [COL_W-1:0] col_nxt;
  logic [2:0]       lives_nxt;
  logic             vis_nxt;
  logic [TW-1:0]    tmr, tmr_nxt;
  logic [COL_W:0]   col_ext, col_mv;
  logic             can_act, move_ok;
`ifdef PLAYER_INVULN_EN
  logic [1:0]       blink, blink_nxt;
`endif

  assign can_act = (life == ALIVE || life == INVULN) && !Hit;
  assign move_ok = can_act && Frame_tick;
  assign col_ext = {1'b0, Player_Col};

  always_comb begin
    if (Joystick_data > JOY_R)
      col_mv = (col_ext + STEP_X > MAX_X) ? MAX_X : col_ext + STEP_X;
    else if (Joystick_data < JOY_L)
      col_mv = (col_ext < MIN_X + STEP_X) ? MIN_X : col_ext - STEP_X;
    else
      col_mv = col_ext;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      life       <= ALIVE;
      Player_Col <= COL_W'(START_COL);
      Lives      <= 3'(LIVES);
      Visible    <= 1'b1;
      tmr        <= '0;
`ifdef PLAYER_INVULN_EN
      blink      <= '0;
`endif
    end else begin
      life       <= life_nxt;
      Player_Col <= col_nxt;
      Lives      <= lives_nxt;
      Visible    <= vis_nxt;
      tmr        <= tmr_nxt;
`ifdef PLAYER_INVULN_EN
      blink      <= blink_nxt;
`endif
    end
  end

  always_comb begin
    life_nxt  = life;
    col_nxt   = Player_Col;
    lives_nxt = Lives;
    vis_nxt   = Visible;
    tmr_nxt   = tmr;
`ifdef PLAYER_INVULN_EN
    blink_nxt = blink;
`endif
    case (life)
      ALIVE: begin
        if (Hit) begin
          vis_nxt = 1'b0;
          if (Lives == 3'd1) begin
            life_nxt  = GAME_OVER;
            lives_nxt = 3'd0;
          end else begin
            life_nxt  = DYING;
            lives_nxt = Lives - 3'd1;
            tmr_nxt   = TW'(RESPAWN_FRAMES);
          end
        end else if (move_ok) begin
          col_nxt = col_mv[COL_W-1:0];
        end
      end
      DYING: begin
        if (tmr == '0) begin
          col_nxt = COL_W'(START_COL);
          vis_nxt = 1'b1;
`ifdef PLAYER_INVULN_EN
          life_nxt  = INVULN;
          tmr_nxt   = TW'(INVULN_FRAMES);
          blink_nxt = '0;
`else
          life_nxt  = ALIVE;
`endif
        end else if (Frame_tick) begin
          tmr_nxt = tmr - TW'(1);
        end
      end
      INVULN: begin
`ifdef PLAYER_INVULN_EN
        if (tmr == '0) begin
          life_nxt = ALIVE;
          vis_nxt  = 1'b1;
        end else begin
          // Blink: flip on every 4th tick counted from entry.
          if (Frame_tick) begin
            tmr_nxt   = tmr - TW'(1);
            blink_nxt = blink + 2'd1;
            if (blink == 2'd3) vis_nxt = !Visible;
          end
          if (move_ok) col_nxt = col_mv[COL_W-1:0];
        end
`else
        life_nxt = ALIVE;
`endif
      end
      GAME_OVER: vis_nxt = 1'b0;
    endcase
  end

  assign Player_Row = ROW_W'(START_ROW);
  assign Game_over  = (life == GAME_OVER);

  player_fire_ctrl #(
    .COL_W     (COL_W),
    .COOLDOWN  (COOLDOWN),
    .START_COL (START_COL)
  ) u_fire (
    .clk         (Clk),
    .reset       (Reset),
    .frame_tick  (Frame_tick),
    .fire_btn    (Fire_btn),
    .fire_enable (can_act),
    .bullet_ack  (Bullet_ack),
    .player_col  (Player_Col),
    .bullet_req  (Bullet_req),
    .bullet_col  (Bullet_col)
  );

endmodule

// File: doc/player_ctrl.md
Name: player_ctrl

Overview:
- Parametrised player-ship controller for the invaders game. Successor to the fixed-constant player block.
- Moves the ship horizontally from joystick data on frame ticks, with clamped bounds.
- Issues fire requests to the bullet unit over a req/ack handshake, with a per-frame cooldown.
- Tracks lives through a hit/respawn/game-over state machine. Sits between the joystick interface, the collision unit, the bullet unit and the VGA renderer.

Parameters:
- ROW_W, 9, row coordinate width
- COL_W, 10, column coordinate width
- START_ROW, 420, fixed ship row
- START_COL, 310, column after reset and after each respawn
- MIN_COL, 5, leftmost legal column
- MAX_COL, 600, rightmost legal column
- STEP, 5, columns moved per frame tick
- JOY_LEFT_TH, 4, Joystick_data below this value moves left
- JOY_RIGHT_TH, 6, Joystick_data above this value moves right
- COOLDOWN, 15, frame ticks between shots (width = clog2(COOLDOWN+1))
- LIVES, 3, starting lives (1..7)
- RESPAWN_FRAMES, 60, frame ticks spent in DYING

Ports:
- Clk  in  1  system clock
- Reset  in  1  synchronous, active-high reset
- Frame_tick  in  1  one-cycle pulse per video frame
- Joystick_data  in  4  joystick X magnitude
- Fire_btn  in  1  fire button, level
- Hit  in  1  one-cycle pulse from collision unit: ship struck
- Bullet_ack  in  1  bullet unit accepts the request
- Player_Row  out  ROW_W  ship row
- Player_Col  out  COL_W  ship column
- Bullet_req  out  1  fire request
- Bullet_col  out  COL_W  launch column, valid while Bullet_req
- Visible  out  1  renderer draws ship
- Lives  out  3  remaining lives
- Game_over  out  1  terminal flag

Behaviour:
- Single clock domain.
- Reset (synchronous, active-high, on Clk) gives:
  - Player_Row=START_ROW, Player_Col=START_COL
  - Bullet_req=0, Bullet_col=START_COL
  - Visible=1, Lives=LIVES, Game_over=0
  - life FSM=ALIVE, fire FSM=READY, cooldown counter=0
- Player_Row is constant START_ROW.
- Movement: evaluated only on a Frame_tick cycle, only in ALIVE or INVULN, and only if Hit=0 that cycle.
  - Joystick_data > JOY_RIGHT_TH: col = min(col+STEP, MAX_COL).
  - Joystick_data < JOY_LEFT_TH: col = max(col-STEP, MIN_COL).
  - Otherwise hold.
  - Arithmetic uses COL_W+1 bits, so no wrap-around. The clamp means the ship lands exactly on the bound and never overshoots.
  - The position updates in the cycle after the tick.
- Fire FSM:
  - READY: when Fire_btn=1, life FSM is ALIVE or INVULN, and Hit=0, go to REQ. Latch Bullet_col=Player_Col. Bullet_req=1 from the next cycle.
  - REQ: Bullet_req held high and Bullet_col held stable until Bullet_ack=1. On the ack cycle go to COOL and load the counter with COOLDOWN. Bullet_req must not drop before the ack, even if the ship is hit.
  - COOL: the counter decrements on each Frame_tick. At 0 go to READY. A held Fire_btn therefore auto-fires every COOLDOWN frames. COOLDOWN=0 means READY on the cycle after the ack.
  - Bullet_ack outside REQ is ignored.
- Life FSM:
  - ALIVE, Hit=1:
    - Lives decrements.
    - If the pre-decrement value was 1: go to GAME_OVER, Lives=0.
    - Otherwise: go to DYING, load the frame counter with RESPAWN_FRAMES, Visible=0.
  - DYING:
    - Hit is ignored. No movement and no new fire.
    - The counter decrements on each Frame_tick.
    - At 0, Player_Col=START_COL, then go to INVULN when PLAYER_INVULN_EN is defined, otherwise to ALIVE.
    - Visible=1 on exit.
  - GAME_OVER: Game_over=1, Visible=0, all inputs ignored, held until Reset.
- Simultaneous events:
  - Hit with Frame_tick: the hit wins and there is no movement.
  - Hit with Fire_btn in READY: no request starts.
  - Reset overrides everything, including a pending REQ; Bullet_req drops on the next edge.

Optional Feature:
- Macro PLAYER_INVULN_EN.
- Defined:
  - Adds parameter INVULN_FRAMES (default 90) and state INVULN, entered after DYING.
  - In INVULN, Hit is ignored; movement and fire are allowed.
  - Visible toggles every 4 Frame_ticks, starting at 1.
  - The state exits to ALIVE with Visible=1 after INVULN_FRAMES ticks.
- Undefined: there is no INVULN state and DYING goes directly to ALIVE.

Decomposition:
- Shared package invaders_pkg holds:
  - the life_state_t enum (ALIVE, DYING, INVULN, GAME_OVER)
  - the fire_state_t enum (READY, REQ, COOL)
  - the joystick threshold constants
  - the screen bound constants shared with the renderer and the bullet unit
- One sub-module, player_fire_ctrl, holds the fire FSM, the cooldown counter and the Bullet_col latch. It takes a fire_enable input from the parent.

Test Plan:
- Movement: Reset, Joystick_data=9, 40 Frame_ticks -> Player_Col steps 310,315,...; reaches 510 after 40 ticks. With MAX_COL=312, it reaches 312 and holds there.
- Left clamp: Player_Col=8, Joystick_data=0, Frame_tick -> Player_Col=5 (clamped, not 3); a further tick leaves it at 5. Joystick_data=5 -> no motion.
- Handshake: Fire_btn=1 at col 310, Bullet_ack held low 10 cycles -> Bullet_req=1 and Bullet_col=310 stable throughout. Ack -> req drops next cycle. 15 Frame_ticks later a second request appears.
- Hit during REQ: Hit while Bullet_req=1 -> Lives 3->2, Visible=0, Bullet_req stays 1 until ack. After 60 Frame_ticks, Player_Col=310 and Visible=1.
- Game over: three Hits, each separated by a completed respawn -> Lives=0, Game_over=1. Then Joystick_data=9, Fire_btn=1 and further Hits cause no change. Reset restores Lives=3.
- PLAYER_INVULN_EN: a Hit during INVULN is ignored (Lives unchanged). Visible toggles every 4 ticks. After 90 ticks the state is ALIVE and the next Hit decrements Lives.
